// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round sequencer.
//   op_t      : operation code presented to the state datapath
//   state_t   : sequencer FSM state encoding, with ST_* constants
//   nr_of()   : number of cipher rounds for a given key size
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE     = 4'd0,
    OP_LOAD     = 4'd1,
    OP_ARK      = 4'd2,
    OP_SUB      = 4'd3,
    OP_SHIFT    = 4'd4,
    OP_MIX      = 4'd5,
    OP_INVSUB   = 4'd6,
    OP_INVSHIFT = 4'd7,
    OP_INVMIX   = 4'd8
  } op_t;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_WAIT_KEY = 3'd2;
  localparam logic [2:0] ST_ARK      = 3'd3;
  localparam logic [2:0] ST_SUB      = 3'd4;
  localparam logic [2:0] ST_SHIFT    = 3'd5;
  localparam logic [2:0] ST_MIX      = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control bus between the round sequencer, the state datapath and the
// key-expansion unit.
//   load, key_valid, decrypt   : towards the sequencer
//   operation, round, key_req,
//   busy, done                 : from the sequencer
// decrypt exists only when AES_DECRYPT_EN is defined.
// Modports: master (drives load/key_valid), slave (the sequencer).
interface aes_round_sequencer_if;
  import aes_ctrl_pkg::*;

  logic       load;
  logic       key_valid;
`ifdef AES_DECRYPT_EN
  logic       decrypt;
`endif
  op_t        operation;
  logic [3:0] round;
  logic       key_req;
  logic       busy;
  logic       done;

`ifdef AES_DECRYPT_EN
  modport master (output load, key_valid, decrypt,
                  input  operation, round, key_req, busy, done);
  modport slave  (input  load, key_valid, decrypt,
                  output operation, round, key_req, busy, done);
`else
  modport master (output load, key_valid,
                  input  operation, round, key_req, busy, done);
  modport slave  (input  load, key_valid,
                  output operation, round, key_req, busy, done);
`endif

endinterface

// File: rtl/aes_round_counter.sv
// Round-key index counter: 4-bit up/down counter with parallel load.
// Saturates at LAST (up) and at 0 (down), so it never wraps.
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : load load_val_i (has priority over inc/dec)
//   inc_i, dec_i  : count up / down
//   count_o       : current round index
//   at_last_o     : count_o == LAST
//   at_first_o    : count_o == 0
module aes_round_counter #(
  parameter logic [3:0] LAST = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       at_last_o,
  output logic       at_first_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != LAST)) begin
      count_d = count_q + 4'd1;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_last_o  = (count_q == LAST);
  assign at_first_o = (count_q == 4'd0);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round controller for AES-128/192/256. Steps the datapath through
// LOAD, AddRoundKey, SubBytes, ShiftRows and MixColumns, requests each
// round key from the key-expansion unit and stalls when a key is late.
// Optional inverse-cipher sequencing is enabled by defining AES_DECRYPT_EN.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : aes_round_sequencer_if.slave
//                (load, key_valid, [decrypt] in; operation, round,
//                 key_req, busy, done out)
// Parameters:
//   KEY_BITS   : 128/192/256, rounds NR = KEY_BITS/32 + 6
//   SUB_CYCLES : 1..4 cycles each SubBytes operation is held
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for load
// LOAD      | datapath loads the block, key for first ARK requested
// WAIT_KEY  | round key not yet delivered
// ARK       | AddRoundKey with key for `round`
// SUB       | (Inv)SubBytes, held SUB_CYCLES cycles
// SHIFT     | (Inv)ShiftRows
// MIX       | (Inv)MixColumns
// DONE      | block finished, done held until next load
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEY_BITS   = 128,
  parameter int unsigned SUB_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  aes_round_sequencer_if.slave bus
);

  localparam int unsigned NR       = nr_of(KEY_BITS);
  localparam logic [3:0]  NR_L     = 4'(NR);
  localparam logic [1:0]  SUB_LAST = 2'(SUB_CYCLES - 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $error("aes_round_sequencer: KEY_BITS must be 128, 192 or 256");
  end
  if (SUB_CYCLES < 1 || SUB_CYCLES > 4) begin : g_bad_sub
    $error("aes_round_sequencer: SUB_CYCLES must be 1..4");
  end

  state_t     state_q, state_d;
  logic [1:0] sub_cnt_q, sub_cnt_d;
  logic       dec_q, dec_d;
  logic       key_rdy_q, key_rdy_d;

  logic       dec_start;
  logic       key_avail;
  logic       key_req;
  logic       cnt_load, cnt_inc, cnt_dec;
  logic [3:0] cnt_load_val;
  logic [3:0] round;
  logic       at_last, at_first;
  op_t        op_c;

`ifdef AES_DECRYPT_EN
  assign dec_start = bus.decrypt;
`else
  assign dec_start = 1'b0;
`endif

  // A key counts as present if it arrives this cycle or arrived early.
  assign key_avail = bus.key_valid | key_rdy_q;

  // One request per new round index: at LOAD, on the first SubBytes cycle
  // after an encrypt increment, and on the InvShiftRows after a decrement.
  assign key_req = (state_q == ST_LOAD) ||
                   (!dec_q && (state_q == ST_SUB) && (sub_cnt_q == 2'd0)) ||
                   ( dec_q && (state_q == ST_SHIFT));

  // A key arriving together with a request is the answer to an earlier one
  // only if it is meant for the new round, so the set wins.
  assign key_rdy_d = bus.key_valid ? 1'b1 : (key_req ? 1'b0 : key_rdy_q);

  aes_round_counter #(.LAST(NR_L)) u_round_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .count_o    (round),
    .at_last_o  (at_last),
    .at_first_o (at_first)
  );

  always_comb begin
    state_d      = state_q;
    sub_cnt_d    = sub_cnt_q;
    dec_d        = dec_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.load) begin
          state_d      = ST_LOAD;
          dec_d        = dec_start;
          cnt_load     = 1'b1;
          cnt_load_val = dec_start ? NR_L : 4'd0;
        end
      end
      ST_LOAD: state_d = ST_WAIT_KEY;
      ST_WAIT_KEY: begin
        if (key_avail) state_d = ST_ARK;
      end
      ST_ARK: begin
        if (!dec_q) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_SUB;
          end
        end else begin
          if (at_first) begin
            state_d = ST_DONE;
          end else if (at_last) begin
            // Initial ARK(NR) is followed directly by InvShiftRows.
            cnt_dec = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_MIX;
          end
        end
      end
      ST_SUB: begin
        if (sub_cnt_q == SUB_LAST) begin
          sub_cnt_d = 2'd0;
          if (dec_q) state_d = key_avail ? ST_ARK : ST_WAIT_KEY;
          else       state_d = ST_SHIFT;
        end else begin
          sub_cnt_d = sub_cnt_q + 2'd1;
        end
      end
      ST_SHIFT: begin
        if (dec_q)         state_d = ST_SUB;
        else if (!at_last) state_d = ST_MIX;
        else               state_d = key_avail ? ST_ARK : ST_WAIT_KEY;
      end
      ST_MIX: begin
        if (dec_q) begin
          cnt_dec = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = key_avail ? ST_ARK : ST_WAIT_KEY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sub_cnt_q <= 2'd0;
      dec_q     <= 1'b0;
      key_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_cnt_q <= sub_cnt_d;
      dec_q     <= dec_d;
      key_rdy_q <= key_rdy_d;
    end
  end

  always_comb begin
    op_c = OP_NONE;
    case (state_q)
      ST_LOAD:  op_c = OP_LOAD;
      ST_ARK:   op_c = OP_ARK;
      ST_SUB:   op_c = dec_q ? OP_INVSUB   : OP_SUB;
      ST_SHIFT: op_c = dec_q ? OP_INVSHIFT : OP_SHIFT;
      ST_MIX:   op_c = dec_q ? OP_INVMIX   : OP_MIX;
      default:  op_c = OP_NONE;
    endcase
  end

  assign bus.operation = op_c;
  assign bus.round     = round;
  assign bus.key_req   = key_req;
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer. Three instances (AES-128 S=1,
// AES-256 S=2, AES-192 S=1) share one clock. A key model answers every
// key_req with a key_valid pulse one cycle later, or later for a chosen
// round. Define AES_DECRYPT_EN to add the inverse-cipher vectors.
module tb_aes_round_sequencer;

  localparam int C_NONE = 0, C_LOAD = 1, C_ARK = 2, C_SUB = 3, C_SHIFT = 4,
                 C_MIX = 5, C_INVSUB = 6, C_INVSHIFT = 7, C_INVMIX = 8;

  typedef struct {
    int dut;
    bit dec;
    int nr;
    int s;
    int stall_round;
    int stall_delay;
    int late;
    int exp_done;
    int exp_round;
  } vec_t;

  logic clk;
  logic reset_v   [3];
  logic load_v    [3];
  logic kv_model  [3];
  logic kv_force  [3];
  logic [3:0] op_v  [3];
  logic [3:0] round_v [3];
  logic key_req_v [3];
  logic busy_v    [3];
  logic done_v    [3];
`ifdef AES_DECRYPT_EN
  logic dec_v     [3];
`endif

  int kv_cnt        [3];
  int stall_round_v [3];
  int stall_delay_v [3];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ops [$];
  int exp_rnd [$];
  vec_t vecs [$];

  aes_round_sequencer_if if0 ();
  aes_round_sequencer_if if1 ();
  aes_round_sequencer_if if2 ();

  aes_round_sequencer #(.KEY_BITS(128), .SUB_CYCLES(1)) u_dut0 (.clk(clk), .reset(reset_v[0]), .bus(if0));
  aes_round_sequencer #(.KEY_BITS(256), .SUB_CYCLES(2)) u_dut1 (.clk(clk), .reset(reset_v[1]), .bus(if1));
  aes_round_sequencer #(.KEY_BITS(192), .SUB_CYCLES(1)) u_dut2 (.clk(clk), .reset(reset_v[2]), .bus(if2));

  assign if0.load = load_v[0];
  assign if1.load = load_v[1];
  assign if2.load = load_v[2];
  assign if0.key_valid = kv_model[0] | kv_force[0];
  assign if1.key_valid = kv_model[1] | kv_force[1];
  assign if2.key_valid = kv_model[2] | kv_force[2];
`ifdef AES_DECRYPT_EN
  assign if0.decrypt = dec_v[0];
  assign if1.decrypt = dec_v[1];
  assign if2.decrypt = dec_v[2];
`endif

  assign op_v[0] = if0.operation;  assign round_v[0] = if0.round;
  assign op_v[1] = if1.operation;  assign round_v[1] = if1.round;
  assign op_v[2] = if2.operation;  assign round_v[2] = if2.round;
  assign key_req_v[0] = if0.key_req; assign busy_v[0] = if0.busy; assign done_v[0] = if0.done;
  assign key_req_v[1] = if1.key_req; assign busy_v[1] = if1.busy; assign done_v[1] = if1.done;
  assign key_req_v[2] = if2.key_req; assign busy_v[2] = if2.busy; assign done_v[2] = if2.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key model: a key_req seen in cycle c yields key_valid in cycle c+delay.
  initial begin
    for (int i = 0; i < 3; i++) begin
      kv_model[i] = 1'b0;
      kv_cnt[i]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        kv_model[i] = 1'b0;
        if (kv_cnt[i] > 0) begin
          kv_cnt[i] = kv_cnt[i] - 1;
          if (kv_cnt[i] == 0) kv_model[i] = 1'b1;
        end
        if (key_req_v[i])
          kv_cnt[i] = (int'(round_v[i]) == stall_round_v[i]) ? stall_delay_v[i] : 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int op, input int rnd);
    exp_ops.push_back(op);
    exp_rnd.push_back(rnd);
  endtask

  // Expected per-cycle operation/round from the load edge up to DONE.
  task automatic gen_expected(input vec_t v);
    exp_ops.delete();
    exp_rnd.delete();
    if (!v.dec) begin
      push(C_LOAD, 0); push(C_NONE, 0); push(C_ARK, 0);
      for (int r = 1; r <= v.nr; r++) begin
        repeat (v.s) push(C_SUB, r);
        push(C_SHIFT, r);
        if (r < v.nr) push(C_MIX, r);
        if (r == v.stall_round) repeat (v.late) push(C_NONE, r);
        push(C_ARK, r);
      end
    end else begin
      push(C_LOAD, v.nr); push(C_NONE, v.nr); push(C_ARK, v.nr);
      for (int r = v.nr - 1; r >= 0; r--) begin
        push(C_INVSHIFT, r);
        repeat (v.s) push(C_INVSUB, r);
        push(C_ARK, r);
        if (r > 0) push(C_INVMIX, r);
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int d;
    int done_edge;
    int bad;
    int first_bad;
    int kreq;
    int got_op, got_rnd, got_busy;
    d = v.dut;
    done_edge = -1;
    bad = 0;
    first_bad = -1;
    kreq = 0;
    got_op = 0; got_rnd = 0; got_busy = 0;
    gen_expected(v);
    stall_round_v[d] = v.stall_round;
    stall_delay_v[d] = v.stall_delay;
    @(negedge clk);
    load_v[d] = 1'b1;
`ifdef AES_DECRYPT_EN
    dec_v[d] = v.dec;
`endif
    @(negedge clk);
    load_v[d] = 1'b0;
    check({tag, " start round"}, int'(round_v[d]), v.dec ? v.nr : 0);
    check({tag, " done cleared on load"}, int'(done_v[d]), 0);
    // Index e counts edges after the edge that sampled load.
    for (int e = 0; e < 400; e++) begin
      if (e > 0) @(negedge clk);
      if (done_v[d]) begin
        // done rises at edge e; the first edge that samples it high is e+1.
        done_edge = e + 1;
        check({tag, " op in DONE"}, int'(op_v[d]), C_NONE);
        check({tag, " busy in DONE"}, int'(busy_v[d]), 0);
        check({tag, " round at done"}, int'(round_v[d]), v.exp_round);
        break;
      end
      kreq += int'(key_req_v[d]);
      if (e >= exp_ops.size() || int'(op_v[d]) != exp_ops[e] ||
          int'(round_v[d]) != exp_rnd[e] || busy_v[d] !== 1'b1) begin
        if (first_bad < 0) begin
          first_bad = e;
          got_op = int'(op_v[d]);
          got_rnd = int'(round_v[d]);
          got_busy = int'(busy_v[d]);
        end
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s trace: %0d bad cycles, first at %0d got op=%0d round=%0d busy=%0d, expected op=%0d round=%0d busy=1",
               tag, bad, first_bad, got_op, got_rnd, got_busy,
               (first_bad < exp_ops.size()) ? exp_ops[first_bad] : -1,
               (first_bad < exp_rnd.size()) ? exp_rnd[first_bad] : -1);
    end
    check({tag, " done edge"}, done_edge, v.exp_done);
    check({tag, " key_req count"}, kreq, v.nr + 1);
    stall_round_v[d] = -1;
  endtask

  initial begin
    int waited;
    vecs.push_back('{dut:0, dec:0, nr:10, s:1, stall_round:-1, stall_delay:1, late:0, exp_done:43, exp_round:10});
    vecs.push_back('{dut:1, dec:0, nr:14, s:2, stall_round:-1, stall_delay:1, late:0, exp_done:73, exp_round:14});
    // Round-3 key 6 cycles after its request: ARK moves from c+3 to c+7.
    vecs.push_back('{dut:0, dec:0, nr:10, s:1, stall_round:3,  stall_delay:6, late:4, exp_done:47, exp_round:10});
    vecs.push_back('{dut:2, dec:0, nr:12, s:1, stall_round:-1, stall_delay:1, late:0, exp_done:51, exp_round:12});
`ifdef AES_DECRYPT_EN
    vecs.push_back('{dut:2, dec:1, nr:12, s:1, stall_round:-1, stall_delay:1, late:0, exp_done:51, exp_round:0});
    vecs.push_back('{dut:0, dec:1, nr:10, s:1, stall_round:-1, stall_delay:1, late:0, exp_done:43, exp_round:0});
`endif

    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b1;
      load_v[i] = 1'b0;
      kv_force[i] = 1'b0;
      stall_round_v[i] = -1;
      stall_delay_v[i] = 1;
`ifdef AES_DECRYPT_EN
      dec_v[i] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) reset_v[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset op[%0d]", i), int'(op_v[i]), C_NONE);
      check($sformatf("reset round[%0d]", i), int'(round_v[i]), 0);
      check($sformatf("reset key_req[%0d]", i), int'(key_req_v[i]), 0);
      check($sformatf("reset busy[%0d]", i), int'(busy_v[i]), 0);
      check($sformatf("reset done[%0d]", i), int'(done_v[i]), 0);
    end

    for (int i = 0; i < vecs.size(); i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // done held in DONE, then a load restarts the AES-256 instance.
    repeat (5) @(negedge clk);
    check("done held", int'(done_v[1]), 1);
    check("round held at NR", int'(round_v[1]), 14);
    run_txn(vecs[1], "restart");

    // load during round 5 is ignored; reset mid-operation returns to IDLE.
    @(negedge clk);
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v[0] = 1'b0;
    waited = 0;
    while (int'(round_v[0]) != 5 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("reach round 5", int'(round_v[0]), 5);
    check("round 5 first op", int'(op_v[0]), C_SUB);
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v[0] = 1'b0;
    check("busy load ignored op", int'(op_v[0]), C_SHIFT);
    check("busy load ignored round", int'(round_v[0]), 5);
    check("busy load ignored busy", int'(busy_v[0]), 1);
    reset_v[0] = 1'b1;
    @(negedge clk);
    reset_v[0] = 1'b0;
    check("mid reset op", int'(op_v[0]), C_NONE);
    check("mid reset round", int'(round_v[0]), 0);
    check("mid reset busy", int'(busy_v[0]), 0);
    check("mid reset key_req", int'(key_req_v[0]), 0);
    check("mid reset done", int'(done_v[0]), 0);
    kv_force[0] = 1'b1;
    @(negedge clk);
    kv_force[0] = 1'b0;
    @(negedge clk);
    check("stale key stays idle", int'(busy_v[0]), 0);
    run_txn(vecs[0], "fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
